// File: rtl/fwd_pkg.sv
// Shared opcode constants, operand-usage decode and the in-flight tracker entry type
// for the forwarding / load-use hazard unit.
package fwd_pkg;

  localparam logic [1:0] OP_RR = 2'b00;
  localparam logic [1:0] OP_RI = 2'b01;
  localparam logic [1:0] OP_LD = 2'b10;
  localparam logic [1:0] OP_BR = 2'b11;

  // Widest register index supported; narrower RW values are zero-extended into dest.
  localparam int MAX_RW = 8;

  typedef struct packed {
    logic              v;
    logic [MAX_RW-1:0] dest;
    logic              ld;
  } inflight_t;

  function automatic logic op_writes(input logic [1:0] op);
    return (op != OP_BR);
  endfunction

  function automatic logic op_reads_a(input logic [1:0] op);
    return (op == OP_RR) || (op == OP_RI);
  endfunction

  function automatic logic op_reads_b(input logic [1:0] op);
    return (op == OP_RR);
  endfunction

endpackage

// File: rtl/fwd_match.sv
// Priority matcher: returns the youngest tracker stage (1-based) whose valid
// destination equals the given register field, or 0 when none / not enabled.
module fwd_match
  import fwd_pkg::*;
#(
  parameter int RW    = 3,
  parameter int DEPTH = 2,
  localparam int SW   = $clog2(DEPTH + 1)
) (
  input  inflight_t [DEPTH-1:0] ents,
  input  logic      [RW-1:0]    field,
  input  logic                  en,
  output logic      [SW-1:0]    sel
);

  logic [MAX_RW-1:0] field_ext;
  assign field_ext = MAX_RW'(field);

  // Walk oldest to youngest so the youngest match is the last one written.
  always_comb begin
    sel = '0;
    for (int k = DEPTH - 1; k >= 0; k--) begin
      if (en && ents[k].v && (ents[k].dest == field_ext))
        sel = SW'(k + 1);
    end
  end

endmodule

// File: rtl/fwd_hazard_unit.sv
// Forwarding + load-use hazard unit: tracks DEPTH in-flight destination writes,
// selects operand sources for the ID/EX instruction and stalls on load-use.
module fwd_hazard_unit
  import fwd_pkg::*;
#(
  parameter int RW    = 3,
  parameter int DEPTH = 2,
  localparam int IW   = 2 + 2 * RW,
  localparam int SW   = $clog2(DEPTH + 1)
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          id_valid,
  input  logic [IW-1:0] id_instr,
  input  logic          flush,
  output logic [SW-1:0] fwd_a,
  output logic [SW-1:0] fwd_b,
  output logic          stall,
  output logic [15:0]   stall_count
);

  logic [1:0]    op;
  logic [RW-1:0] fld_a;
  logic [RW-1:0] fld_b;
  logic          rd_a;
  logic          rd_b;

  assign op    = id_instr[IW-1 -: 2];
  assign fld_a = id_instr[2*RW-1 -: RW];
  assign fld_b = id_instr[RW-1:0];
  assign rd_a  = id_valid && op_reads_a(op);
  assign rd_b  = id_valid && op_reads_b(op);

  inflight_t [DEPTH-1:0] trk_q, trk_d;
  logic      [15:0]      stall_count_q, stall_count_d;

  fwd_match #(.RW(RW), .DEPTH(DEPTH)) u_match_a (
    .ents  (trk_q),
    .field (fld_a),
    .en    (rd_a),
    .sel   (fwd_a)
  );

  fwd_match #(.RW(RW), .DEPTH(DEPTH)) u_match_b (
    .ents  (trk_q),
    .field (fld_b),
    .en    (rd_b),
    .sel   (fwd_b)
  );

  // Load data is not available until stage 2, so only a stage-1 load can stall.
  always_comb begin
    stall = 1'b0;
    if (id_valid && trk_q[0].v && trk_q[0].ld) begin
      if (rd_a && (trk_q[0].dest == MAX_RW'(fld_a))) stall = 1'b1;
      if (rd_b && (trk_q[0].dest == MAX_RW'(fld_b))) stall = 1'b1;
    end
  end

  always_comb begin
    trk_d = trk_q;
    for (int k = DEPTH - 1; k >= 1; k--)
      trk_d[k] = trk_q[k-1];
    trk_d[0].v    = id_valid && op_writes(op) && !stall;
    trk_d[0].dest = MAX_RW'(fld_a);
    trk_d[0].ld   = (op == OP_LD);
    if (flush)
      trk_d = '0;
  end

  always_comb begin
    stall_count_d = stall_count_q;
    if (stall && (stall_count_q != 16'hFFFF))
      stall_count_d = stall_count_q + 16'd1;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      trk_q         <= '0;
      stall_count_q <= '0;
    end else begin
      trk_q         <= trk_d;
      stall_count_q <= stall_count_d;
    end
  end

  assign stall_count = stall_count_q;

endmodule

// File: tb/tb_fwd_hazard_unit.sv
// Directed bench for fwd_hazard_unit: DEPTH=2 main instance plus a DEPTH=1 instance
// sharing the same stimulus for the single-stage load-use case.
module tb_fwd_hazard_unit;

  logic       clk = 1'b0;
  logic       reset;
  logic       id_valid;
  logic [7:0] id_instr;
  logic       flush;

  logic [1:0]  fwd_a, fwd_b;
  logic        stall;
  logic [15:0] stall_count;

  logic        d1_fwd_a, d1_fwd_b;
  logic        d1_stall;
  logic [15:0] d1_stall_count;

  int n_chk  = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  fwd_hazard_unit #(.RW(3), .DEPTH(2)) dut (
    .clk         (clk),
    .reset       (reset),
    .id_valid    (id_valid),
    .id_instr    (id_instr),
    .flush       (flush),
    .fwd_a       (fwd_a),
    .fwd_b       (fwd_b),
    .stall       (stall),
    .stall_count (stall_count)
  );

  fwd_hazard_unit #(.RW(3), .DEPTH(1)) dut_d1 (
    .clk         (clk),
    .reset       (reset),
    .id_valid    (id_valid),
    .id_instr    (id_instr),
    .flush       (flush),
    .fwd_a       (d1_fwd_a),
    .fwd_b       (d1_fwd_b),
    .stall       (d1_stall),
    .stall_count (d1_stall_count)
  );

  task automatic chk(input string tag, input int got, input int exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  // Present one ID/EX instruction for a cycle; returns at the negedge for sampling.
  task automatic apply(input logic v, input logic [7:0] i, input logic f);
    @(posedge clk);
    #1;
    id_valid = v;
    id_instr = i;
    flush    = f;
    @(negedge clk);
  endtask

  task automatic chk_out(input string tag, input int ea, input int eb, input int es);
    chk({tag, ".fwd_a"}, int'(fwd_a), ea);
    chk({tag, ".fwd_b"}, int'(fwd_b), eb);
    chk({tag, ".stall"}, int'(stall), es);
  endtask

  initial begin
    reset    = 1'b1;
    id_valid = 1'b1;
    id_instr = 8'b00_001_010;
    flush    = 1'b0;

    // Reset held two cycles with a valid instruction in ID
    apply(1'b1, 8'b00_001_010, 1'b0);
    apply(1'b1, 8'b00_001_010, 1'b0);
    chk_out("reset", 0, 0, 0);
    chk("reset.count", int'(stall_count), 0);
    id_valid = 1'b0;
    reset    = 1'b0;

    // Back-to-back ALU
    apply(1'b1, 8'b00_001_010, 1'b0);
    chk_out("alu0", 0, 0, 0);
    apply(1'b1, 8'b00_011_001, 1'b0);
    chk_out("alu1", 0, 1, 0);
    apply(1'b1, 8'b01_001_000, 1'b0);
    chk_out("alu2", 2, 0, 0);

    // Nearest producer wins
    apply(1'b1, 8'b01_100_000, 1'b0);
    chk_out("near0", 0, 0, 0);
    apply(1'b1, 8'b01_100_000, 1'b0);
    chk_out("near1", 1, 0, 0);
    apply(1'b1, 8'b00_100_100, 1'b0);
    chk_out("near2", 1, 1, 0);

    // Load-use: DEPTH=2 forwards from stage 2, DEPTH=1 falls back to regfile
    apply(1'b1, 8'b10_101_000, 1'b0);
    chk_out("ld0", 0, 0, 0);
    chk("ld0.d1_stall", int'(d1_stall), 0);
    apply(1'b1, 8'b00_101_000, 1'b0);
    chk_out("ld1", 1, 0, 1);
    chk("ld1.count", int'(stall_count), 0);
    chk("ld1.d1_stall", int'(d1_stall), 1);
    apply(1'b1, 8'b00_101_000, 1'b0);
    chk_out("ld2", 2, 0, 0);
    chk("ld2.count", int'(stall_count), 1);
    chk("ld2.d1_fwd_a", int'(d1_fwd_a), 0);
    chk("ld2.d1_stall", int'(d1_stall), 0);
    chk("ld2.d1_count", int'(d1_stall_count), 1);

    // Flush: outputs from pre-flush state, then tracker empty
    apply(1'b1, 8'b01_010_000, 1'b0);
    chk_out("fl0", 0, 0, 0);
    apply(1'b1, 8'b00_010_010, 1'b1);
    chk_out("fl1", 1, 1, 0);
    apply(1'b1, 8'b00_010_010, 1'b0);
    chk_out("fl2", 0, 0, 0);

    // Branch-class producer never forwards or stalls
    apply(1'b1, 8'b11_011_011, 1'b0);
    chk_out("br0", 0, 0, 0);
    apply(1'b1, 8'b00_011_011, 1'b0);
    chk_out("br1", 0, 0, 0);
    // Load followed by a non-reading instruction
    apply(1'b1, 8'b10_011_000, 1'b0);
    apply(1'b1, 8'b11_011_011, 1'b0);
    chk_out("ldbr", 0, 0, 0);

    // Invalid consumer after a load: no stall, then load visible at stage 2
    apply(1'b1, 8'b10_110_000, 1'b0);
    apply(1'b0, 8'b00_110_110, 1'b0);
    chk_out("inv0", 0, 0, 0);
    apply(1'b1, 8'b00_110_110, 1'b0);
    chk_out("inv1", 2, 2, 0);
    chk("inv1.count", int'(stall_count), 1);

    // Saturation: preload counter near the top, then drive load-use pairs
    force dut.stall_count_q = 16'hFFF0;
    #1;
    release dut.stall_count_q;
    for (int p = 0; p < 5; p++) begin
      apply(1'b1, 8'b10_111_000, 1'b0);
      apply(1'b1, 8'b01_111_000, 1'b0);
    end
    apply(1'b0, 8'b00_000_000, 1'b0);
    chk("sat.mid", int'(stall_count), 16'hFFF5);
    for (int p = 0; p < 15; p++) begin
      apply(1'b1, 8'b10_111_000, 1'b0);
      apply(1'b1, 8'b01_111_000, 1'b0);
    end
    chk("sat.stall", int'(stall), 1);
    apply(1'b0, 8'b00_000_000, 1'b0);
    chk("sat.top", int'(stall_count), 16'hFFFF);
    apply(1'b1, 8'b10_111_000, 1'b0);
    apply(1'b1, 8'b01_111_000, 1'b0);
    apply(1'b0, 8'b00_000_000, 1'b0);
    chk("sat.hold", int'(stall_count), 16'hFFFF);

    // Mid-operation reset discards in-flight producers and clears the counter
    apply(1'b1, 8'b10_111_000, 1'b0);
    reset = 1'b1;
    apply(1'b1, 8'b01_111_000, 1'b1);
    chk("rst2.count", int'(stall_count), 0);
    reset    = 1'b0;
    id_valid = 1'b0;
    flush    = 1'b0;
    apply(1'b1, 8'b00_111_111, 1'b0);
    chk_out("rst2", 0, 0, 0);
    chk("rst2.count_after", int'(stall_count), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
